sfr_paged_slave: RTL and testbench

SFR_PAGED_SLAVE -- requirements
Module: sfr_paged_slave

---
 rtl/sfr_paged_slave.sv | 100 ++++++++++
 tb/tb_sfr_paged_slave.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/sfr_paged_slave.sv
// sfr_paged_slave: paged SFR slave with wait states, page-select register and error pulse
module sfr_paged_slave #(
   parameter int ADDR_WIDTH    = 8,
   parameter int DATA_WIDTH    = 8,
   parameter int PAGE_NUM      = 4,
   parameter int NUM_REGS      = 8,
   parameter int BASE_ADDR     = 8'h90,
   parameter int PAGE_REG_ADDR = 8'h98,
   parameter int WAIT_STATES   = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [ADDR_WIDTH-1:0]       sfraddr,
   input  logic                        sfrwe,
   input  logic                        sfroe,
   input  logic [DATA_WIDTH-1:0]       sfrdatao,
   output logic                        sfrack,
   output logic [DATA_WIDTH-1:0]       sfrdatai,
   output logic [$clog2(PAGE_NUM)-1:0] sfr_page_sel,
   output logic                        err
);
   localparam int PW = $clog2(PAGE_NUM);
   localparam int NR = PAGE_NUM * NUM_REGS;
   localparam int IW = $clog2(NR);
   localparam logic [ADDR_WIDTH-1:0] LO = ADDR_WIDTH'(BASE_ADDR);
   localparam logic [ADDR_WIDTH-1:0] HI = ADDR_WIDTH'(BASE_ADDR + NUM_REGS - 1);
   localparam logic [ADDR_WIDTH-1:0] PA = ADDR_WIDTH'(PAGE_REG_ADDR);
   typedef enum logic [1:0] {IDLE, WAIT, ACK, RECOVER} state_t;
   state_t state, state_n;
   logic [2:0] cnt, cnt_n;
   logic [ADDR_WIDTH-1:0] a_addr, c_addr;
   logic [DATA_WIDTH-1:0] a_wdata, c_wdata;
   logic [PW-1:0] page, a_page, c_page;
   logic [DATA_WIDTH-1:0] regs [NR];
   logic a_we, a_both, c_we, hit, req, abort, abort_q, commit, bad_page;
   function automatic logic [IW-1:0] idx(input logic [PW-1:0] p, input logic [ADDR_WIDTH-1:0] a);
      return IW'(p) * IW'(NUM_REGS) + IW'(a - LO);
   endfunction
   // With zero wait states the commit edge is also the latch edge, so use live inputs in IDLE
   always_comb begin
      hit      = (sfraddr >= LO && sfraddr <= HI) || sfraddr == PA;
      req      = sfrwe | sfroe;
      c_addr   = state == IDLE ? sfraddr : a_addr;
      c_wdata  = state == IDLE ? sfrdatao : a_wdata;
      c_we     = state == IDLE ? sfrwe : a_we;
      c_page   = state == IDLE ? page : a_page;
      state_n  = state;
      cnt_n    = cnt;
      abort    = 1'b0;
      case (state)
         IDLE: if (hit && req) begin
            state_n = WAIT_STATES > 0 ? WAIT : ACK;
            cnt_n   = '0;
         end
         WAIT: if (!req) begin
            state_n = IDLE;
            abort   = 1'b1;
         end else if (int'(cnt) + 1 >= WAIT_STATES) state_n = ACK;
         else cnt_n = cnt + 3'd1;
         ACK:     state_n = RECOVER;
         default: state_n = IDLE;
      endcase
      commit   = state_n == ACK && c_we;
      bad_page = c_wdata >= DATA_WIDTH'(PAGE_NUM);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         abort_q <= 1'b0;
         page    <= '0;
         a_addr  <= '0;
         a_wdata <= '0;
         a_page  <= '0;
         a_we    <= 1'b0;
         a_both  <= 1'b0;
         for (int i = 0; i < NR; i++) regs[i] <= '0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         abort_q <= abort;
         if (state == IDLE && hit && req) begin
            a_addr  <= sfraddr;
            a_wdata <= sfrdatao;
            a_page  <= page;
            a_we    <= sfrwe;
            a_both  <= sfrwe & sfroe;
         end
         if (commit) begin
            if (c_addr == PA) begin
               if (!bad_page) page <= c_wdata[PW-1:0];
            end else regs[idx(c_page, c_addr)] <= c_wdata;
         end
      end
   end
   assign sfrack       = state == ACK;
   assign sfr_page_sel = page;
   assign sfrdatai     = (state == ACK && !a_we) ? (a_addr == PA ? DATA_WIDTH'(page) : regs[idx(a_page, a_addr)]) : '0;
   assign err          = abort_q | (state == ACK && (a_both || (a_we && a_addr == PA && a_wdata >= DATA_WIDTH'(PAGE_NUM))));
endmodule

// File: tb/tb_sfr_paged_slave.sv
// tb_sfr_paged_slave: transaction-level model with per-cycle output timeline plus literal pins
module tb_sfr_paged_slave;
   localparam int W = 1;
   localparam int MAXC = 1000;
   logic clk = 1'b0, rst = 1'b1, sfrwe = 1'b0, sfroe = 1'b0, sfrack, err;
   logic [7:0] sfraddr = '0, sfrdatao = '0, sfrdatai;
   logic [1:0] sfr_page_sel;
   int cyc = 0, checks = 0, failures = 0;
   bit e_ack [MAXC];
   bit e_err [MAXC];
   bit [7:0] e_dat [MAXC];
   bit [1:0] e_pg [MAXC];
   bit [7:0] mem [32];
   int m_page = 0;
   logic [7:0] rd;
   sfr_paged_slave #(.WAIT_STATES(W)) dut (
      .clk(clk), .rst(rst), .sfraddr(sfraddr), .sfrwe(sfrwe), .sfroe(sfroe),
      .sfrdatao(sfrdatao), .sfrack(sfrack), .sfrdatai(sfrdatai),
      .sfr_page_sel(sfr_page_sel), .err(err)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%h expected=%h", nm, cyc, act, exp);
      end
   endtask
   always @(negedge clk) if (cyc > 0 && cyc < MAXC) begin
      chk("ack", 8'(sfrack), 8'(e_ack[cyc]));
      chk("rdata", sfrdatai, e_dat[cyc]);
      chk("err", 8'(err), 8'(e_err[cyc]));
      chk("page", 8'(sfr_page_sel), 8'(e_pg[cyc]));
   end
   task automatic step(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask
   function automatic bit is_hit(input logic [7:0] a);
      return (a >= 8'h90 && a <= 8'h97) || a == 8'h98;
   endfunction
   task automatic drop();
      sfrwe = 1'b0;
      sfroe = 1'b0;
   endtask
   // A serialized transfer: the model applies it at issue and books the outputs on the ack cycle
   task automatic xfer(input bit we, input bit oe, input logic [7:0] a, input logic [7:0] d, input bit glitch, output logic [7:0] r);
      int n, t;
      sfrwe = we; sfroe = oe; sfraddr = a; sfrdatao = d;
      n = cyc + 1;
      t = n + W;
      r = 'x;
      if (!is_hit(a)) begin
         step(20);
         drop();
         step(2);
         return;
      end
      e_ack[t] = 1'b1;
      if (we) begin
         if (oe) e_err[t] = 1'b1;
         if (a == 8'h98) begin
            if (d < 4) begin
               m_page = int'(d);
               for (int k = t; k < MAXC; k++) e_pg[k] = d[1:0];
            end else e_err[t] = 1'b1;
         end else mem[m_page * 8 + int'(a - 8'h90)] = d;
      end else e_dat[t] = a == 8'h98 ? 8'(m_page) : mem[m_page * 8 + int'(a - 8'h90)];
      step(1);
      if (glitch) begin
         sfraddr  = a + 8'd1;
         sfrdatao = ~d;
      end
      while (cyc < t) step(1);
      r = sfrdatai;
      drop();
      step(2);
   endtask
   initial begin
      step(3);
      chk("rst_ack", 8'(sfrack), 8'h00);
      chk("rst_page", 8'(sfr_page_sel), 8'h00);
      rst = 1'b0;
      step(2);
      xfer(1, 0, 8'h92, 8'h5A, 0, rd);
      xfer(0, 1, 8'h92, 8'h00, 0, rd);
      chk("pin_rd_92", rd, 8'h5A);
      xfer(1, 0, 8'h98, 8'h02, 0, rd);
      xfer(1, 0, 8'h90, 8'hA5, 0, rd);
      xfer(1, 0, 8'h98, 8'h00, 0, rd);
      xfer(0, 1, 8'h90, 8'h00, 0, rd);
      chk("pin_p0_90", rd, 8'h00);
      xfer(1, 0, 8'h98, 8'h02, 0, rd);
      xfer(0, 1, 8'h90, 8'h00, 0, rd);
      chk("pin_p2_90", rd, 8'hA5);
      xfer(1, 0, 8'h98, 8'h07, 0, rd);
      chk("pin_badpage_sel", 8'(sfr_page_sel), 8'h02);
      xfer(0, 1, 8'h98, 8'h00, 0, rd);
      chk("pin_rd_pagereg", rd, 8'h02);
      xfer(0, 1, 8'hA0, 8'h00, 0, rd);
      xfer(1, 1, 8'h93, 8'h33, 0, rd);
      xfer(0, 1, 8'h93, 8'h00, 0, rd);
      chk("pin_both_93", rd, 8'h33);
      xfer(1, 0, 8'h94, 8'h11, 1, rd);
      xfer(0, 1, 8'h95, 8'h00, 0, rd);
      chk("pin_glitch_95", rd, 8'h00);
      xfer(0, 1, 8'h94, 8'h00, 0, rd);
      chk("pin_glitch_94", rd, 8'h11);
      begin : abort_case
         int n;
         sfroe = 1'b1; sfraddr = 8'h90;
         n = cyc + 1;
         step(1);
         sfroe = 1'b0;
         e_err[n + 1] = 1'b1;
         step(3);
      end
      xfer(0, 1, 8'h90, 8'h00, 0, rd);
      chk("pin_after_abort", rd, 8'hA5);
      xfer(1, 0, 8'h98, 8'h01, 0, rd);
      begin : reset_case
         int n;
         sfrwe = 1'b1; sfraddr = 8'h91; sfrdatao = 8'h77;
         n = cyc + 1;
         step(1);
         rst = 1'b1;
         step(1);
         rst = 1'b0;
         drop();
         m_page = 0;
         for (int k = 0; k < 32; k++) mem[k] = '0;
         for (int k = n + 1; k < MAXC; k++) e_pg[k] = '0;
         step(2);
      end
      xfer(0, 1, 8'h91, 8'h00, 0, rd);
      chk("pin_rst_91", rd, 8'h00);
      chk("pin_rst_page", 8'(sfr_page_sel), 8'h00);
      xfer(0, 1, 8'h92, 8'h00, 0, rd);
      chk("pin_rst_92", rd, 8'h00);
      step(3);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
